// File: rtl/cache_bus_arbiter.sv
// Round-robin arbiter sharing one cache port among N_CORES cores.
// The owner keeps the bus until it signals done, drops its request, or the watchdog expires.
module cache_bus_arbiter #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CORES-1:0]          req,
  input  logic [2*N_CORES-1:0]        rw_req,
  input  logic [ADDR_W*N_CORES-1:0]   addr_req,
  input  logic [DATA_W*N_CORES-1:0]   wdata_req,
  input  logic [N_CORES-1:0]          core_done,
  output logic [N_CORES-1:0]          gnt,
  output logic [1:0]                  cache_rw,
  output logic [ADDR_W-1:0]           cache_addr,
  output logic [DATA_W-1:0]           cache_wdata,
  output logic [$clog2(N_CORES)-1:0]  owner_id,
  output logic                        busy,
  output logic                        timeout_err,
  output logic [7:0]                  err_cnt
);

  // state   | meaning
  // IDLE    | no owner; pick the next eligible core round-robin from ptr
  // BUSY    | owner drives the cache bus; watchdog running
  // RELEASE | one-cycle bus turnaround; ptr advances past the owner

  localparam int ID_W = $clog2(N_CORES);
  localparam int WD_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   owner, owner_nxt;
  logic [ID_W-1:0]   ptr, ptr_nxt;
  logic [WD_W-1:0]   wd, wd_nxt;
  logic [N_CORES-1:0] eligible;
  logic              pick_valid;
  logic [ID_W-1:0]   pick_idx;
  logic              to_hit;

  always_comb begin
    for (int i = 0; i < N_CORES; i++) begin
      eligible[i] = req[i] && (rw_req[2*i +: 2] == 2'b10 || rw_req[2*i +: 2] == 2'b01);
    end
  end

  // Walk the search order backwards so the candidate closest to ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = N_CORES - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % N_CORES;
      if (eligible[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    wd_nxt    = wd;
    to_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          owner_nxt = pick_idx;
          wd_nxt    = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        wd_nxt = wd + 1'b1;
        if (core_done[owner] || !req[owner]) begin
          state_nxt = RELEASE;
        end else if (wd == WD_W'(TIMEOUT - 1)) begin
          state_nxt = RELEASE;
          to_hit    = 1'b1;
        end
      end
      RELEASE: begin
        ptr_nxt   = (int'(owner) == N_CORES - 1) ? '0 : owner + 1'b1;
        wd_nxt    = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= '0;
      ptr         <= '0;
      wd          <= '0;
      timeout_err <= 1'b0;
      err_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      ptr         <= ptr_nxt;
      wd          <= wd_nxt;
      timeout_err <= to_hit;
      if (to_hit && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  // Grant and bus mux decode only from registered state/owner.
  always_comb begin
    busy        = (state == BUSY);
    gnt         = '0;
    cache_rw    = '0;
    cache_addr  = '0;
    cache_wdata = '0;
    owner_id    = '0;
    if (busy) begin
      gnt         = N_CORES'(1) << owner;
      cache_rw    = rw_req[2*int'(owner) +: 2];
      cache_addr  = addr_req[ADDR_W*int'(owner) +: ADDR_W];
      cache_wdata = wdata_req[DATA_W*int'(owner) +: DATA_W];
      owner_id    = owner;
    end
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter (4 cores, 12-bit address, 8-bit data, TIMEOUT 15).
module tb_cache_bus_arbiter;
  logic        clk, rst;
  logic [3:0]  req, core_done, gnt;
  logic [7:0]  rw_req;
  logic [47:0] addr_req;
  logic [31:0] wdata_req;
  logic [1:0]  cache_rw, owner_id;
  logic [11:0] cache_addr;
  logic [7:0]  cache_wdata, err_cnt;
  logic        busy, timeout_err;

  int passed = 0;
  int total  = 0;

  cache_bus_arbiter #(.N_CORES(4), .ADDR_W(12), .DATA_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req(req), .rw_req(rw_req), .addr_req(addr_req),
    .wdata_req(wdata_req), .core_done(core_done), .gnt(gnt), .cache_rw(cache_rw),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .owner_id(owner_id),
    .busy(busy), .timeout_err(timeout_err), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int i, input logic r, input logic [1:0] rw,
                          input logic [11:0] a, input logic [7:0] d);
    req[i]              = r;
    rw_req[2*i +: 2]    = rw;
    addr_req[12*i +: 12] = a;
    wdata_req[8*i +: 8] = d;
  endtask

  task automatic clear_inputs;
    req = '0; rw_req = '0; addr_req = '0; wdata_req = '0; core_done = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input int limit, output int n, output logic ok);
    n = 0; ok = 1'b0;
    while (n < limit && !ok) begin
      tick();
      n++;
      if (gnt !== 4'b0000) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got %b want 0000", gnt); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (err_cnt !== 8'd0 || timeout_err !== 1'b0) $display("FAIL reset_err got %0d/%b want 0/0", err_cnt, timeout_err); else passed++;
    total++; if (cache_rw !== 2'b00 || cache_addr !== 12'h000 || owner_id !== 2'd0) $display("FAIL reset_bus got %b/%h/%0d want 00/000/0", cache_rw, cache_addr, owner_id); else passed++;
  endtask

  task automatic test_single;
    set_core(2, 1'b1, 2'b10, 12'h3A5, 8'h5C);
    total++; if (gnt !== 4'b0000) $display("FAIL single_latency got %b want 0000", gnt); else passed++;
    tick();
    total++; if (gnt !== 4'b0100 || busy !== 1'b1) $display("FAIL single_gnt got %b/%b want 0100/1", gnt, busy); else passed++;
    total++; if (cache_rw !== 2'b10 || cache_addr !== 12'h3A5 || cache_wdata !== 8'h5C) $display("FAIL single_mux got %b/%h/%h want 10/3a5/5c", cache_rw, cache_addr, cache_wdata); else passed++;
    total++; if (owner_id !== 2'd2) $display("FAIL single_owner got %0d want 2", owner_id); else passed++;
    set_core(2, 1'b1, 2'b01, 12'h123, 8'hA7);
    core_done[0] = 1'b1;
    #1;
    total++; if (cache_rw !== 2'b01 || cache_addr !== 12'h123 || cache_wdata !== 8'hA7) $display("FAIL single_follow got %b/%h/%h want 01/123/a7", cache_rw, cache_addr, cache_wdata); else passed++;
    tick();
    core_done[0] = 1'b0;
    total++; if (gnt !== 4'b0100) $display("FAIL single_foreign_done got %b want 0100", gnt); else passed++;
    core_done[2] = 1'b1;
    tick();
    core_done[2] = 1'b0;
    req[2] = 1'b0;
    total++; if (gnt !== 4'b0000 || busy !== 1'b0 || cache_addr !== 12'h000 || cache_rw !== 2'b00) $display("FAIL single_release got %b/%b/%h/%b want 0000/0/000/00", gnt, busy, cache_addr, cache_rw); else passed++;
    total++; if (timeout_err !== 1'b0) $display("FAIL single_no_timeout got %b want 0", timeout_err); else passed++;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL single_idle got %b want 0", busy); else passed++;
  endtask

  task automatic test_all_four;
    int n; logic ok;
    logic [3:0] want;
    do_reset();
    for (int k = 0; k < 4; k++) set_core(k, 1'b1, 2'b10, 12'h100 + 12'(k), 8'h10 + 8'(k));
    for (int k = 0; k < 4; k++) begin
      want = 4'b0001 << k;
      wait_gnt(6, n, ok);
      total++; if (!ok || gnt !== want) $display("FAIL all4_order[%0d] got %b want %b", k, gnt, want); else passed++;
      total++; if (n !== ((k == 0) ? 1 : 2)) $display("FAIL all4_gap[%0d] got %0d want %0d", k, n, (k == 0) ? 1 : 2); else passed++;
      total++; if (cache_addr !== 12'h100 + 12'(k)) $display("FAIL all4_addr[%0d] got %h want %h", k, cache_addr, 12'h100 + 12'(k)); else passed++;
      tick();
      core_done[k] = 1'b1;
      tick();
      core_done[k] = 1'b0;
      req[k] = 1'b0;
      total++; if (gnt !== 4'b0000) $display("FAIL all4_release[%0d] got %b want 0000", k, gnt); else passed++;
    end
    tick();
  endtask

  task automatic test_alternate;
    int n; logic ok;
    int seq [4] = '{0, 3, 0, 3};
    logic [3:0] want;
    do_reset();
    set_core(0, 1'b1, 2'b01, 12'h0AA, 8'h01);
    set_core(3, 1'b1, 2'b01, 12'h0BB, 8'h02);
    for (int j = 0; j < 4; j++) begin
      want = 4'b0001 << seq[j];
      wait_gnt(6, n, ok);
      total++; if (!ok || gnt !== want) $display("FAIL alt_order[%0d] got %b want %b", j, gnt, want); else passed++;
      core_done[seq[j]] = 1'b1;
      tick();
      core_done = '0;
    end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_masked;
    int n; logic ok;
    int seen;
    do_reset();
    set_core(0, 1'b1, 2'b00, 12'h001, 8'h00);
    set_core(1, 1'b1, 2'b11, 12'h011, 8'h00);
    set_core(2, 1'b1, 2'b01, 12'h022, 8'h33);
    wait_gnt(6, n, ok);
    total++; if (!ok || gnt !== 4'b0100 || cache_rw !== 2'b01) $display("FAIL masked_pick got %b/%b want 0100/01", gnt, cache_rw); else passed++;
    core_done[2] = 1'b1;
    tick();
    core_done[2] = 1'b0;
    req[2] = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (gnt !== 4'b0000) seen++;
    end
    total++; if (seen !== 0) $display("FAIL masked_never got %0d grant cycles want 0", seen); else passed++;
    clear_inputs();
    tick();
  endtask

  task automatic test_timeout;
    int n; logic ok;
    do_reset();
    set_core(1, 1'b1, 2'b10, 12'h111, 8'h11);
    wait_gnt(6, n, ok);
    total++; if (!ok || gnt !== 4'b0010) $display("FAIL to_gnt got %b want 0010", gnt); else passed++;
    set_core(3, 1'b1, 2'b10, 12'h333, 8'h33);
    n = 1;
    while (n < 40) begin
      tick();
      if (gnt === 4'b0010) n++;
      else break;
    end
    total++; if (n !== 15) $display("FAIL to_busy_cycles got %0d want 15", n); else passed++;
    total++; if (gnt !== 4'b0000 || timeout_err !== 1'b1) $display("FAIL to_release got %b/%b want 0000/1", gnt, timeout_err); else passed++;
    total++; if (err_cnt !== 8'd1) $display("FAIL to_err_cnt got %0d want 1", err_cnt); else passed++;
    tick();
    total++; if (timeout_err !== 1'b0) $display("FAIL to_pulse_width got %b want 0", timeout_err); else passed++;
    tick();
    total++; if (gnt !== 4'b1000) $display("FAIL to_next_owner got %b want 1000", gnt); else passed++;
    core_done[3] = 1'b1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_rst_mid;
    int n; logic ok;
    set_core(3, 1'b1, 2'b10, 12'h3C3, 8'h3C);
    wait_gnt(6, n, ok);
    total++; if (!ok || gnt !== 4'b1000) $display("FAIL rstmid_gnt got %b want 1000", gnt); else passed++;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (gnt !== 4'b0000 || busy !== 1'b0 || err_cnt !== 8'd0) $display("FAIL rstmid_clear got %b/%b/%0d want 0000/0/0", gnt, busy, err_cnt); else passed++;
    tick();
    total++; if (gnt !== 4'b1000 || cache_addr !== 12'h3C3) $display("FAIL rstmid_regrant got %b/%h want 1000/3c3", gnt, cache_addr); else passed++;
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_err_saturate;
    int p;
    int want_cnt;
    do_reset();
    set_core(1, 1'b1, 2'b10, 12'h0F0, 8'hF0);
    p = 0;
    for (int c = 0; c < 4430; c++) begin
      tick();
      if (timeout_err === 1'b1) p++;
    end
    want_cnt = (p > 255) ? 255 : p;
    total++; if (p !== 260) $display("FAIL sat_pulses got %0d want 260", p); else passed++;
    total++; if (err_cnt !== 8'(want_cnt)) $display("FAIL sat_err_cnt got %0d want %0d", err_cnt, want_cnt); else passed++;
    clear_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_all_four();
    test_alternate();
    test_masked();
    test_timeout();
    test_rst_mid();
    test_err_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule
